// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared switch-path types and defaults for sw_debounce and sum
package sw_pkg;

  localparam int SW_WIDTH = 2;
  localparam int SW_SYNC_STAGES_DEFAULT = 2;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one-bit synchroniser, stability counter and stable-level register
module sw_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   differ;

  assign s = sync[SYNC_STAGES-1];

  // Decide whether the synced level has differed from the stable level long enough to commit.
  always_comb begin
    differ  = 1'b0;
    changed = 1'b0;
    differ  = (s != level);
    changed = differ && (cnt == CNT_LAST);
  end

  // Shift the raw switch through the synchroniser and run the stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw};
      if (!differ) begin
        cnt <= '0;
      end else if (changed) begin
        cnt   <= '0;
        level <= s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounced switch vector with change strobe; SW_DEBOUNCE_EDGE_EN enables rise/fall pulses
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = SW_SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic             o_chg,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (i_clk),
      .rst    (i_rst),
      .sw     (i_sw[i]),
      .level  (level[i]),
      .changed(changed[i])
    );
  end

  assign o_sw = level;

  // Strobe lands on the same edge the stable level updates, so it marks the new value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_chg <= 1'b0;
    end else begin
      o_chg <= |changed;
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // A committing bit that is currently low is rising; one that is currently high is falling.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rise <= '0;
      o_fall <= '0;
    end else begin
      o_rise <= changed & ~level;
      o_fall <= changed & level;
    end
  end
`else
  assign o_rise = '0;
  assign o_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce (DEBOUNCE_CYCLES=4)
module tb_sw_debounce;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_sw;
  logic [1:0] o_sw;
  logic       o_chg;
  logic [1:0] o_rise;
  logic [1:0] o_fall;

  int checks;
  int failures;

  sw_debounce #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sw  (i_sw),
    .o_sw  (o_sw),
    .o_chg (o_chg),
    .o_rise(o_rise),
    .o_fall(o_fall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle(input logic [1:0] v);
    i_sw = v;
    repeat (10) step();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_sw  = 2'b00;
    #2;
    for (int k = 0; k < 6; k++) begin
      i_sw = 2'(k);
      step();
      checks++;
      if (o_sw !== 2'b00 || o_chg !== 1'b0 || o_rise !== 2'b00 || o_fall !== 2'b00) begin
        failures++;
        $display("FAIL reset_hold k=%0d o_sw=%b o_chg=%b o_rise=%b o_fall=%b required 00/0/00/00",
                 k, o_sw, o_chg, o_rise, o_fall);
      end
    end
    i_sw  = 2'b00;
    step();
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (o_sw !== 2'b00 || o_chg !== 1'b0 || o_rise !== 2'b00 || o_fall !== 2'b00) begin
        failures++;
        $display("FAIL reset_release k=%0d o_sw=%b o_chg=%b required 00/0", k, o_sw, o_chg);
      end
    end
  endtask

  // Apply v after an edge, then check old value through edge 5, new value + strobe at 6, strobe gone at 7.
  task automatic run_step(input string name, input logic [1:0] old_v, input logic [1:0] v,
                          input logic [1:0] exp_rise, input logic [1:0] exp_fall);
    logic [1:0] er;
    logic [1:0] ef;
`ifdef SW_DEBOUNCE_EDGE_EN
    er = exp_rise;
    ef = exp_fall;
`else
    er = 2'b00;
    ef = 2'b00;
`endif
    i_sw = v;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (o_sw !== old_v || o_chg !== 1'b0) begin
        failures++;
        $display("FAIL %s_early edge=%0d o_sw=%b o_chg=%b required %b/0", name, k, o_sw, o_chg, old_v);
      end
    end
    step();
    checks++;
    if (o_sw !== v || o_chg !== 1'b1 || o_rise !== er || o_fall !== ef) begin
      failures++;
      $display("FAIL %s_update o_sw=%b o_chg=%b o_rise=%b o_fall=%b required %b/1/%b/%b",
               name, o_sw, o_chg, o_rise, o_fall, v, er, ef);
    end
    step();
    checks++;
    if (o_sw !== v || o_chg !== 1'b0 || o_rise !== 2'b00 || o_fall !== 2'b00) begin
      failures++;
      $display("FAIL %s_after o_sw=%b o_chg=%b o_rise=%b o_fall=%b required %b/0/00/00",
               name, o_sw, o_chg, o_rise, o_fall, v);
    end
  endtask

  task automatic test_step();
    run_step("step01", 2'b00, 2'b01, 2'b01, 2'b00);
    repeat (4) step();
    run_step("step00", 2'b01, 2'b00, 2'b00, 2'b01);
    repeat (4) step();
  endtask

  task automatic test_glitch();
    int chg_seen;
    chg_seen = 0;
    i_sw = 2'b10;
    repeat (3) step();
    i_sw = 2'b00;
    for (int k = 0; k < 12; k++) begin
      if (o_chg === 1'b1) chg_seen++;
      checks++;
      if (o_sw !== 2'b00) begin
        failures++;
        $display("FAIL glitch_level k=%0d o_sw=%b required 00", k, o_sw);
      end
      step();
    end
    checks++;
    if (chg_seen !== 0) begin
      failures++;
      $display("FAIL glitch_chg strobes=%0d required 0", chg_seen);
    end
    run_step("hold10", 2'b00, 2'b10, 2'b10, 2'b00);
    settle(2'b00);
  endtask

  task automatic test_back_to_back();
    run_step("both11", 2'b00, 2'b11, 2'b11, 2'b00);
    repeat (4) step();
    run_step("both00", 2'b11, 2'b00, 2'b00, 2'b11);
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    i_sw = 2'b01;
    repeat (4) step();
    #1;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_sw !== 2'b00 || o_chg !== 1'b0 || o_rise !== 2'b00 || o_fall !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_async o_sw=%b o_chg=%b required 00/0", o_sw, o_chg);
    end
    repeat (2) step();
    i_rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (o_sw !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_early edge=%0d o_sw=%b required 00", k, o_sw);
      end
    end
    step();
    checks++;
    if (o_sw !== 2'b01 || o_chg !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_update o_sw=%b o_chg=%b required 01/1", o_sw, o_chg);
    end
    settle(2'b00);
  endtask

  task automatic test_counting();
    logic [1:0] hist[$];
    logic [1:0] seq[4];
    logic [1:0] exp_v;
    seq[0] = 2'b00;
    seq[1] = 2'b01;
    seq[2] = 2'b10;
    seq[3] = 2'b11;
    for (int k = 0; k < 5; k++) hist.push_back(2'b00);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 10; c++) begin
        i_sw = seq[p];
        hist.push_back(seq[p]);
        step();
        exp_v = hist.pop_front();
        checks++;
        if (o_sw !== exp_v) begin
          failures++;
          $display("FAIL counting p=%0d c=%0d o_sw=%b required %b", p, c, o_sw, exp_v);
        end
      end
    end
    settle(2'b00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst    = 1'b1;
    i_sw     = 2'b00;
    test_reset();
    test_step();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_counting();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage directly upstream of the `sum` block. It drives `sum.i_sw` from raw board switches.
- Each switch bit is resynchronised into `i_clk` and debounced with a per-bit stability counter.
- Outputs are a clean, glitch-free switch vector plus optional per-bit edge pulses.
- Guarantees `sum` only sees changes that have been stable for `DEBOUNCE_CYCLES` clocks.

Parameters:
- WIDTH, 2, number of switch bits; matches the `sum` input width.
- SYNC_STAGES, 2, synchroniser flop depth; legal values ≥2.
- DEBOUNCE_CYCLES, 1000, consecutive synced cycles a new level must hold before `o_sw` changes; legal values ≥1.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous reset, active-high. One clock domain; reset asserts asynchronously and deasserts synchronously externally.
- i_sw  input  WIDTH  raw asynchronous switch levels.
- o_sw  output  WIDTH  debounced switch levels; connects to `sum.i_sw`.
- o_chg  output  1  one-cycle strobe, high in the cycle after any `o_sw` bit changed.
- o_rise  output  WIDTH  one-cycle per-bit rising-edge pulses (optional feature).
- o_fall  output  WIDTH  one-cycle per-bit falling-edge pulses (optional feature).

Behaviour:
- Reset values while `i_rst` is high: all synchroniser flops, counters, `o_sw`, `o_chg`, `o_rise` and `o_fall` are 0.
- Synchroniser: per-bit `SYNC_STAGES` flop chain. `s[i]` is the last stage.
- Debounce, per bit `i`, one counter of width `$clog2(DEBOUNCE_CYCLES+1)`:
  - `s[i] == o_sw[i]`: counter cleared to 0.
  - `s[i] != o_sw[i]` and counter `< DEBOUNCE_CYCLES-1`: counter increments.
  - `s[i] != o_sw[i]` and counter `== DEBOUNCE_CYCLES-1`: `o_sw[i] <= s[i]`, counter cleared.
- Latency: a clean step on `i_sw[i]` reaches `o_sw[i]` exactly `SYNC_STAGES + DEBOUNCE_CYCLES` clock edges after the first edge that samples it.
- Glitch rejection: a synced pulse shorter than `DEBOUNCE_CYCLES` cycles is discarded and `o_sw` is unchanged. Any return to the current `o_sw` level restarts the count from 0.
- `DEBOUNCE_CYCLES == 1`: `o_sw` follows `s` with one cycle of delay.
- Bits are fully independent; simultaneous changes on several bits update in the same cycle if their counters expire together.
- `o_chg` is the registered OR over bits of (`o_sw` next `!=` `o_sw` current). It is exactly one cycle wide per update cycle, and back-to-back updates give back-to-back strobes.
- Counters never wrap: the maximum value held is `DEBOUNCE_CYCLES-1`.
- Reset mid-count: all state clears immediately, and a pending change is lost. After release, a held input needs the full latency again to re-propagate.
- `o_sw` is registered with no combinational path from `i_sw`.

Optional Feature:
- Macro: `SW_DEBOUNCE_EDGE_EN`.
- Defined:
  - `o_rise[i]` is a one-cycle pulse in the same cycle as `o_chg` when `o_sw[i]` went 0→1.
  - `o_fall[i]` is the same for 1→0.
  - Both are registered and reset to 0.
- Undefined: the edge registers are not built, and `o_rise` and `o_fall` are tied to 0. Ports remain present so the top level is unchanged.

Decomposition:
- Shared package `sw_pkg`:
  - `localparam SW_WIDTH = 2`.
  - `typedef logic [SW_WIDTH-1:0] sw_vec_t`, also used by `sum` and its bench.
  - `localparam SW_SYNC_STAGES_DEFAULT = 2`.
- Sub-module `sw_debounce_bit`: synchroniser, counter and stable-level register for one bit. It outputs `level` and `changed`.
- The top module instantiates `sw_debounce_bit` `WIDTH` times in a generate loop and builds `o_chg`, `o_rise` and `o_fall` from the per-bit outputs.

Test Plan (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock):
- Hold `i_rst=1` and toggle `i_sw` → `o_sw=00`, `o_chg=0`, `o_rise=o_fall=00` throughout; release then `i_sw=00` → all outputs stay 0.
- Clean step `i_sw 00→01` at edge N → `o_sw=01` exactly at edge N+6; `o_chg=1` for one cycle; `o_rise=01` (with EDGE_EN), otherwise `00`.
- 3-cycle glitch `i_sw 00→10→00` → `o_sw` stays `00` and `o_chg` never asserts; then a 4-cycle hold of `10` → `o_sw=10` at +6 edges.
- Both bits stepped together, `00→11` → both bits update on the same edge with a single `o_chg` pulse; `o_rise=11`. Then `11→00` → `o_fall=11`.
- Assert `i_rst` at count 2 of a pending `00→01` change → outputs clear asynchronously. After release with `i_sw=01` held → `o_sw=01` after the full 6 edges, not earlier.
- Counting sequence `00,01,10,11`, each held 10 cycles, into `sum` → `o_sw` follows with 6-cycle latency and `sum.o_led` equals the popcount of `o_sw` 3 cycles later.
